// File: rtl/modulo_entrada_pkg.sv
// Shared definitions for the keyboard-side entry path: FSM encodings,
// digit limits and display widths common with the 7-segment output module.
package modulo_entrada_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        COLETA = 2'd1,
        PRONTO = 2'd2
    } estado_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Display-width constants (same digit layout as the output path)
    localparam int DIGITO_W        = 4;
    localparam int DISPLAY_DIGITOS = 4;
    localparam int BCD_W           = DIGITO_W * DISPLAY_DIGITOS;

    // 14 bits hold up to 9999; the result bus toward the processor is 32 bits
    localparam int ACC_W   = 14;
    localparam int VALOR_W = 32;

    // x*10 built from two shifts so no multiplier is inferred
    function automatic logic [ACC_W-1:0] vezes_dez(input logic [ACC_W-1:0] x);
        return (x << 3) + (x << 1);
    endfunction

endpackage

// File: rtl/modulo_entrada_debounce_botao.sv
// Raw push-button conditioning: 2-flop synchronizer, stability filter and a
// one-cycle press pulse on each accepted 0->1 change of the filtered level.
module debounce_botao #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic botao,
    output logic pulso
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS) + 1;
    localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    logic          sinc_a;
    logic          sinc_b;
    logic          nivel;
    logic [CW-1:0] cont;

    // Two-stage synchronizer for the asynchronous button
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sinc_a <= 1'b0;
            sinc_b <= 1'b0;
        end else begin
            sinc_a <= botao;
            sinc_b <= sinc_a;
        end
    end

    // Accept a new level once it differed from the current one for
    // DEBOUNCE_CICLOS consecutive samples; any bounce back restarts the count
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cont  <= '0;
            nivel <= 1'b0;
            pulso <= 1'b0;
        end else begin
            pulso <= 1'b0;
            if (sinc_b == nivel) begin
                cont <= '0;
            end else if (cont == CONT_MAX) begin
                cont  <= '0;
                nivel <= sinc_b;
                pulso <= sinc_b;
            end else begin
                cont <= cont + CW'(1);
            end
        end
    end

endmodule

// File: rtl/modulo_entrada.sv
// Collects up to MAX_DIGITOS decimal digits from switches/buttons and hands
// the binary value to the processor's input instruction.
//
// Handshake: pedido_entrada is a level request held high by the processor
// for as long as it wants a value. entrada_pronta is a single-cycle valid
// strobe; valor_entrada is new in exactly that cycle and there is no
// back-pressure, so the consumer must take it then. Dropping the request
// while digits are being collected abandons the entry without a strobe.
module modulo_entrada
    import modulo_entrada_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int MAX_DIGITOS     = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [3:0]         chaves,
    input  logic               botao_digito,
    input  logic               botao_enter,
    input  logic               botao_limpa,
    input  logic               pedido_entrada,
    output logic               esperando,
    output logic               entrada_pronta,
    output logic [VALOR_W-1:0] valor_entrada,
    output logic [BCD_W-1:0]   digitos_bcd,
    output logic               erro_digito,
    output logic [1:0]         estado_atual
);

    localparam int CNT_W = $clog2(MAX_DIGITOS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITOS);

    estado_t            estado, estado_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [CNT_W-1:0]   cont, cont_n;
    logic [BCD_W-1:0]   bcd, bcd_n;
    logic [VALOR_W-1:0] valor, valor_n;
    logic               erro_q, erro_n;
    logic [3:0]         chaves_a, chaves_b;
    logic               ev_digito, ev_enter, ev_limpa;

    debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_deb_digito (
        .clock(clock), .reset_n(reset_n), .botao(botao_digito), .pulso(ev_digito)
    );
    debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_deb_enter (
        .clock(clock), .reset_n(reset_n), .botao(botao_enter), .pulso(ev_enter)
    );
    debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_deb_limpa (
        .clock(clock), .reset_n(reset_n), .botao(botao_limpa), .pulso(ev_limpa)
    );

    // Synchronize the switches; long settled before any debounced press
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            chaves_a <= '0;
            chaves_b <= '0;
        end else begin
            chaves_a <= chaves;
            chaves_b <= chaves_a;
        end
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado <= OCIOSO;
            acc    <= '0;
            cont   <= '0;
            bcd    <= '0;
            valor  <= '0;
            erro_q <= 1'b0;
        end else begin
            estado <= estado_n;
            acc    <= acc_n;
            cont   <= cont_n;
            bcd    <= bcd_n;
            valor  <= valor_n;
            erro_q <= erro_n;
        end
    end

    // Next-state and datapath updates; event priority limpa > enter > digito
    always_comb begin
        estado_n = estado;
        acc_n    = acc;
        cont_n   = cont;
        bcd_n    = bcd;
        valor_n  = valor;
        erro_n   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (pedido_entrada) begin
                    estado_n = COLETA;
                    acc_n    = '0;
                    cont_n   = '0;
                    bcd_n    = '0;
                end
            end
            COLETA: begin
                if (!pedido_entrada) begin
                    estado_n = OCIOSO;
                end else if (ev_limpa) begin
                    acc_n  = '0;
                    cont_n = '0;
                    bcd_n  = '0;
                end else if (ev_enter) begin
                    estado_n = PRONTO;
                    valor_n  = VALOR_W'(acc);
                end else if (ev_digito) begin
                    if ((chaves_b <= BCD_MAX) && (cont < CNT_MAX)) begin
                        acc_n  = vezes_dez(acc) + ACC_W'(chaves_b);
                        cont_n = cont + CNT_W'(1);
                        bcd_n  = {bcd[BCD_W-DIGITO_W-1:0], chaves_b};
                    end else begin
                        erro_n = 1'b1;
                    end
                end
            end
            PRONTO: begin
                estado_n = OCIOSO;
            end
            default: begin
                estado_n = OCIOSO;
            end
        endcase
    end

    assign esperando      = (estado == COLETA);
    assign entrada_pronta = (estado == PRONTO);
    assign valor_entrada  = valor;
    assign digitos_bcd    = bcd;
    assign erro_digito    = erro_q;
    assign estado_atual   = estado;

endmodule

// File: tb/tb_modulo_entrada.sv
// Directed bench for modulo_entrada with a short debounce window.
module tb_modulo_entrada;

    logic        clock;
    logic        reset_n;
    logic [3:0]  chaves;
    logic        botao_digito, botao_enter, botao_limpa;
    logic        pedido_entrada;
    logic        esperando, entrada_pronta, erro_digito;
    logic [31:0] valor_entrada;
    logic [15:0] digitos_bcd;
    logic [1:0]  estado_atual;

    int n_assert = 0;
    int n_fail   = 0;
    int ciclo    = 0;
    int raise_ciclo = 0;
    int pronto_ciclo = -1;
    int pronto_cnt = 0;
    int push_cnt   = 0;
    int erro_cnt   = 0;
    int erro_exp   = 0;
    logic [15:0] bcd_at_pronto = '0;
    logic [31:0] exp_q[$];

    modulo_entrada #(.DEBOUNCE_CICLOS(4), .MAX_DIGITOS(4)) dut (
        .clock(clock), .reset_n(reset_n), .chaves(chaves),
        .botao_digito(botao_digito), .botao_enter(botao_enter), .botao_limpa(botao_limpa),
        .pedido_entrada(pedido_entrada), .esperando(esperando),
        .entrada_pronta(entrada_pronta), .valor_entrada(valor_entrada),
        .digitos_bcd(digitos_bcd), .erro_digito(erro_digito), .estado_atual(estado_atual)
    );

    // Clock and cycle counter
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) ciclo++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every pronto pops one expected value
    always @(negedge clock) begin
        if (erro_digito === 1'b1) erro_cnt++;
        if (entrada_pronta === 1'b1) begin
            pronto_cnt++;
            pronto_ciclo  = ciclo;
            bcd_at_pronto = digitos_bcd;
            check("esperando_at_pronto", {31'd0, esperando}, 32'd0);
            if (exp_q.size() == 0)
                check("unexpected_pronto", 32'd1, 32'd0);
            else
                check("valor_entrada", valor_entrada, exp_q.pop_front());
        end
    end

    // Drivers: a press holds the buttons 10 cycles, then releases 10 cycles
    task automatic press(input logic [3:0] val, input logic dig, input logic ent, input logic lim);
        @(posedge clock); #1;
        chaves = val;
        botao_digito = dig;
        botao_enter  = ent;
        botao_limpa  = lim;
        raise_ciclo  = ciclo;
        repeat (10) @(posedge clock);
        #1;
        botao_digito = 1'b0;
        botao_enter  = 1'b0;
        botao_limpa  = 1'b0;
        repeat (10) @(posedge clock);
    endtask

    task automatic digit(input logic [3:0] val);
        press(val, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic enter(input logic [31:0] expected);
        exp_q.push_back(expected);
        push_cnt++;
        press(4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic hold_digit(input logic [3:0] val, input int hi, input int lo);
        @(posedge clock); #1;
        chaves = val;
        botao_digito = 1'b1;
        repeat (hi) @(posedge clock);
        #1;
        botao_digito = 1'b0;
        repeat (lo) @(posedge clock);
    endtask

    initial begin
        // Reset with every button pressed
        reset_n = 1'b0;
        chaves = 4'd9;
        botao_digito = 1'b1;
        botao_enter  = 1'b1;
        botao_limpa  = 1'b1;
        pedido_entrada = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_esperando", {31'd0, esperando}, 32'd0);
        check("rst_pronto", {31'd0, entrada_pronta}, 32'd0);
        check("rst_valor", valor_entrada, 32'd0);
        check("rst_bcd", {16'd0, digitos_bcd}, 32'd0);
        check("rst_erro", {31'd0, erro_digito}, 32'd0);
        check("rst_estado", {30'd0, estado_atual}, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        botao_digito = 1'b0;
        botao_enter  = 1'b0;
        botao_limpa  = 1'b0;
        repeat (12) @(posedge clock);
        @(negedge clock);
        check("post_rst_esperando", {31'd0, esperando}, 32'd1);
        check("post_rst_bcd", {16'd0, digitos_bcd}, 32'd0);
        check("post_rst_no_events", erro_cnt + pronto_cnt, 0);

        // Basic entry 1,2,3,4
        digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4);
        @(negedge clock);
        check("bcd_1234", {16'd0, digitos_bcd}, 32'h1234);
        enter(32'd1234);
        // Raise -> 2 sync edges -> 4 stable samples (event) -> PRONTO next edge
        check("enter_latency", pronto_ciclo - raise_ciclo, 7);
        check("bcd_at_pronto_1234", {16'd0, bcd_at_pronto}, 32'h1234);

        // Fifth digit rejected
        digit(4'd9); digit(4'd9); digit(4'd9); digit(4'd9);
        check("no_erro_4_digits", erro_cnt, erro_exp);
        digit(4'd7);
        erro_exp++;
        check("erro_fifth_digit", erro_cnt, erro_exp);
        enter(32'd9999);

        // Non-BCD switch value rejected, count unchanged
        digit(4'd1); digit(4'd2); digit(4'd3);
        digit(4'hC);
        erro_exp++;
        check("erro_non_bcd", erro_cnt, erro_exp);
        digit(4'd4);
        check("no_erro_after_C", erro_cnt, erro_exp);
        @(negedge clock);
        check("bcd_after_C", {16'd0, digitos_bcd}, 32'h1234);
        enter(32'd1234);

        // Clear in the middle
        digit(4'd5); digit(4'd6);
        press(4'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        check("bcd_after_limpa", {16'd0, digitos_bcd}, 32'd0);
        digit(4'd7);
        @(negedge clock);
        check("bcd_0007", {16'd0, digitos_bcd}, 32'h0007);
        enter(32'd7);

        // Enter and digit in the same cycle: enter wins, digit discarded
        digit(4'd4);
        exp_q.push_back(32'd4);
        push_cnt++;
        press(4'd5, 1'b1, 1'b1, 1'b0);
        check("bcd_enter_digit_same", {16'd0, bcd_at_pronto}, 32'h0004);

        // Bounce shorter than the window -> nothing
        hold_digit(4'd3, 2, 2);
        hold_digit(4'd3, 2, 2);
        hold_digit(4'd3, 2, 10);
        @(negedge clock);
        check("bcd_bounce_none", {16'd0, digitos_bcd}, 32'd0);
        // Bounce then stable hold -> exactly one digit
        hold_digit(4'd3, 1, 1);
        hold_digit(4'd3, 10, 10);
        @(negedge clock);
        check("bcd_bounce_one", {16'd0, digitos_bcd}, 32'h0003);
        check("erro_bounce", erro_cnt, erro_exp);
        enter(32'd3);

        // Request dropped mid-entry: no pronto, value kept
        digit(4'd8); digit(4'd8);
        @(posedge clock); #1;
        pedido_entrada = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("drop_esperando", {31'd0, esperando}, 32'd0);
        check("drop_estado", {30'd0, estado_atual}, 32'd0);
        check("drop_valor_kept", valor_entrada, 32'd3);

        // Reset during collection: entry discarded, value cleared
        @(posedge clock); #1;
        pedido_entrada = 1'b1;
        digit(4'd2); digit(4'd1);
        @(posedge clock); #1;
        reset_n = 1'b0;
        pedido_entrada = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("midrst_valor", valor_entrada, 32'd0);
        check("midrst_esperando", {31'd0, esperando}, 32'd0);
        check("midrst_bcd", {16'd0, digitos_bcd}, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock);

        check("pronto_count", pronto_cnt, push_cnt);
        check("queue_empty", exp_q.size(), 0);
        check("erro_total", erro_cnt, erro_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/modulo_entrada.md
Name: modulo_entrada

Overview:
Keyboard-side counterpart of the 7-segment output path. Collects up to 4 decimal digits from board switches and debounced push-buttons and converts them to a 32-bit binary value for the processor's input instruction. Uses a request/ready handshake and echoes the typed digits as BCD, so the display path can show the entry in progress.

Parameters:
DEBOUNCE_CICLOS, 50000, clock cycles a button level must be stable before it is accepted (sim: 4)
MAX_DIGITOS, 4, maximum digits accepted per entry (value range 0..9999)

Ports:
clock  input  1  system clock, all logic on posedge
reset_n  input  1  synchronous reset, active-low
chaves  input  4  digit value from switches (BCD, raw/asynchronous)
botao_digito  input  1  raw button, high = pressed: append digit
botao_enter  input  1  raw button, high = pressed: finish entry
botao_limpa  input  1  raw button, high = pressed: clear entry
pedido_entrada  input  1  processor requests a value (level)
esperando  output  1  high while collecting digits
entrada_pronta  output  1  one-cycle pulse: valor_entrada is new
valor_entrada  output  32  binary result, zero-extended
digitos_bcd  output  16  echo {d1,d2,d3,d4}, d4 = least significant digit
erro_digito  output  1  one-cycle pulse: digit rejected

Behaviour:
- Reset (reset_n=0 at a posedge): state OCIOSO; all outputs 0; accumulator, digit count, synchronizers and debounce counters cleared. Reset mid-entry discards the entry and raises no pronto.
- Input path: 2-flop synchronizer on chaves and on each button. Debounce then accepts a new level only after it has been stable DEBOUNCE_CICLOS consecutive cycles. Press event = one-cycle pulse on a 0->1 change of the debounced level. Release produces no event.
- Digit is sampled from the synchronized chaves in the same cycle as the press event.
- FSM states:
  - OCIOSO: esperando=0. If pedido_entrada=1, go to COLETA and clear accumulator, count and digitos_bcd.
  - COLETA: esperando=1.
    - Event priority: limpa > enter > digito. Lower-priority events in the same cycle are discarded.
    - limpa: accumulator=0, count=0, digitos_bcd=0. Stay in COLETA.
    - enter: go to PRONTO. Zero digits entered gives value 0.
    - digito, chaves<=9 and count<MAX_DIGITOS: accumulator = accumulator*10 + chaves; count++; digitos_bcd = {digitos_bcd[11:0], chaves}.
    - digito, chaves>9 or count==MAX_DIGITOS: erro_digito=1 for one cycle; no state change.
    - pedido_entrada drops to 0: go to OCIOSO; no pronto; valor_entrada unchanged.
  - PRONTO: lasts one cycle. entrada_pronta=1 and valor_entrada=accumulator in the same cycle; esperando=0. Go to OCIOSO. If pedido_entrada is still 1, OCIOSO restarts a new entry on the next cycle.
- Latency: enter press event in cycle N, then PRONTO (pronto=1, valor valid) in cycle N+1.
- valor_entrada holds its last value until the next PRONTO.
- Accumulator is 14 bits (max 9999). Multiply by 10 is implemented as (x<<3)+(x<<1). No overflow is possible because of the MAX_DIGITOS limit.
- digitos_bcd stays valid after PRONTO until the next entry starts.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: OCIOSO=2'd0, COLETA=2'd1, PRONTO=2'd2.
  - BCD_MAX=4'd9.
  - Display-width constants, shared with the output module.
- Sub-module debounce_botao, instantiated 3 times. Contains the synchronizer, the stability counter (width = clog2(DEBOUNCE_CICLOS)+1) and the rising-edge pulse.

Test Plan (DEBOUNCE_CICLOS=4):
- Reset held 3 cycles with buttons pressed -> all outputs 0; state OCIOSO; no press events after release of reset until a real edge.
- pedido=1; digits 1,2,3,4; then enter -> digitos_bcd=16'h1234; pronto pulse one cycle later; valor_entrada=1234; esperando drops.
- 5 digits 9,9,9,9,7 -> fifth press gives erro_digito pulse; on enter valor=9999. Separately, chaves=4'hC -> erro pulse, count unchanged.
- Digits 5,6; limpa; digit 7; enter -> valor=7, digitos_bcd=16'h0007. Separately, enter and digito events in the same cycle after "4" -> valor=4.
- Button bounce 1-0-1 with pulses shorter than 4 cycles -> no event. Held stable 4+ cycles -> exactly one digit accepted.
- pedido dropped after digits 8,8 -> OCIOSO, no pronto, valor keeps previous value. Reset asserted mid-COLETA -> valor=0, no pronto.
